// File: rtl/bh_pkg.sv
// Shared types and helpers for the branch-history controller.
package bh_pkg;

  localparam int HIST_W     = 32;  // default global-history length
  localparam int DEPTH      = 8;   // default checkpoint queue depth
  localparam int HIST_MAX_W = 64;  // widest history hist_shift can carry

  typedef logic [HIST_W-1:0]       hist_t;
  typedef logic [$clog2(DEPTH):0]  ptr_t;  // MSB is the wrap bit

  // Shift one outcome into a history; bit 0 holds the newest outcome.
  // Callers narrower than HIST_MAX_W zero-extend in and size-cast out.
  function automatic logic [HIST_MAX_W-1:0] hist_shift(
    input logic [HIST_MAX_W-1:0] h,
    input logic                  b
  );
    return {h[HIST_MAX_W-2:0], b};
  endfunction

endpackage

// File: rtl/branch_hist_ctrl_if.sv
// Predict / resolve / retire channel between the front end and the
// history controller.
//
// Handshake: a predict is accepted on a clk edge where predict_valid and
// predict_ready are both high; predict_tag names the checkpoint it gets.
// predict_ready depends only on registered queue state, never on inputs.
// resolve_valid and retire_valid are fire-and-forget: the controller
// always consumes them in the cycle they are presented.
interface branch_hist_ctrl_if #(
  parameter int TAG_W = 3
);
  logic             predict_valid;
  logic             predict_taken;
  logic             predict_ready;
  logic [TAG_W-1:0] predict_tag;
  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             resolve_mispredict;
  logic             resolve_taken;
  logic             retire_valid;
  logic             retire_taken;

  modport master (
    output predict_valid, predict_taken,
    output resolve_valid, resolve_tag, resolve_mispredict, resolve_taken,
    output retire_valid, retire_taken,
    input  predict_ready, predict_tag
  );

  modport slave (
    input  predict_valid, predict_taken,
    input  resolve_valid, resolve_tag, resolve_mispredict, resolve_taken,
    input  retire_valid, retire_taken,
    output predict_ready, predict_tag
  );
endinterface

// File: rtl/bh_ckpt_queue.sv
// Circular checkpoint queue: one speculative-history snapshot per
// in-flight branch, written at tail, read asynchronously by tag.
module bh_ckpt_queue import bh_pkg::*; #(
  parameter int W     = HIST_W,
  parameter int D     = DEPTH,
  parameter int TAG_W = $clog2(D)
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             push,       // already qualified by the caller
  input  logic [W-1:0]     push_data,
  input  logic             pop,        // ignored while empty
  input  logic             trunc,      // drop every entry younger than trunc_tag
  input  logic [TAG_W-1:0] trunc_tag,
  input  logic             flush,      // empty the queue
  output logic [W-1:0]     rd_data,
  output logic [TAG_W-1:0] tail_idx,
  output logic [TAG_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [TAG_W:0] PTR_ONE = 1;

  logic [W-1:0]     ckpt_q [D];
  logic [TAG_W:0]   head_q, tail_q, head_n, tail_n;
  logic [TAG_W-1:0] offset;

  assign count    = tail_q - head_q;
  assign empty    = (head_q == tail_q);
  assign full     = (head_q[TAG_W-1:0] == tail_q[TAG_W-1:0]) &&
                    (head_q[TAG_W] != tail_q[TAG_W]);
  assign tail_idx = tail_q[TAG_W-1:0];
  assign rd_data  = ckpt_q[trunc_tag];

  // Distance of the truncation tag from head; rebuilding tail from head
  // keeps the wrap bit consistent even when the live range wraps.
  assign offset = trunc_tag - head_q[TAG_W-1:0];

  // Pointer update: flush beats truncate beats push; pop is independent.
  always_comb begin
    head_n = head_q;
    tail_n = tail_q;
    if (pop && !empty) head_n = head_q + PTR_ONE;
    if (flush) begin
      head_n = tail_q;
    end else if (trunc) begin
      tail_n = head_q + {1'b0, offset} + PTR_ONE;
    end else if (push) begin
      tail_n = tail_q + PTR_ONE;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_n;
      tail_q <= tail_n;
    end
  end

  // Checkpoint storage; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push && !flush && !trunc) ckpt_q[tail_idx] <= push_data;
  end

endmodule

// File: rtl/branch_hist_ctrl.sv
// Global branch-history controller: speculative history updated at
// predict, architectural history updated at retire, one-cycle repair
// from per-branch checkpoints on a mispredict.
module branch_hist_ctrl import bh_pkg::*; #(
  parameter int W     = HIST_W,   // must not exceed HIST_MAX_W
  parameter int D     = DEPTH,
  parameter int TAG_W = $clog2(D)
) (
  input  logic                   clk,
  input  logic                   reset,   // asynchronous, active-low
  input  logic                   clear,
  branch_hist_ctrl_if.slave      bus,
  output logic [W-1:0]           spec_hist,
  output logic [W-1:0]           arch_hist,
  output logic [TAG_W:0]         count,
  output logic                   full,
  output logic                   empty
);

  logic             mispredict, accept, retire_ok;
  logic [W-1:0]     spec_n, arch_n, ckpt_rd;
  logic [TAG_W-1:0] tail_idx;

  function automatic logic [W-1:0] shift_w(input logic [W-1:0] h, input logic b);
    return W'(hist_shift(HIST_MAX_W'(h), b));
  endfunction

  assign mispredict        = bus.resolve_valid && bus.resolve_mispredict;
  assign accept            = bus.predict_valid && !full && !clear && !mispredict;
  assign retire_ok         = bus.retire_valid && !empty;
  assign bus.predict_ready = !full;
  assign bus.predict_tag   = tail_idx;

  bh_ckpt_queue #(.W(W), .D(D), .TAG_W(TAG_W)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (spec_hist),
    .pop       (bus.retire_valid),
    .trunc     (mispredict),
    .trunc_tag (bus.resolve_tag),
    .flush     (clear),
    .rd_data   (ckpt_rd),
    .tail_idx  (tail_idx),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Architectural history advances only on a retire of a live branch.
  always_comb begin
    arch_n = arch_hist;
    if (retire_ok) arch_n = shift_w(arch_hist, bus.retire_taken);
  end

  // Speculative history: clear > mispredict repair > accepted predict.
  // On clear it follows the post-retire architectural history.
  always_comb begin
    spec_n = spec_hist;
    if (clear)           spec_n = arch_n;
    else if (mispredict) spec_n = shift_w(ckpt_rd, bus.resolve_taken);
    else if (accept)     spec_n = shift_w(spec_hist, bus.predict_taken);
  end

  // History registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spec_hist <= '0;
      arch_hist <= '0;
    end else begin
      spec_hist <= spec_n;
      arch_hist <= arch_n;
    end
  end

endmodule

// File: tb/tb_branch_hist_ctrl.sv
// Directed bench for branch_hist_ctrl: the driver pushes hand-computed
// post-edge state into exp_q, a negedge monitor pops and compares.
module tb_branch_hist_ctrl;

  localparam int W     = 32;
  localparam int D     = 8;
  localparam int TAG_W = 3;
  localparam int EXP_W = 2*W + (TAG_W+1) + 3 + TAG_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic [W-1:0]   spec_hist, arch_hist;
  logic [TAG_W:0] count;
  logic           full, empty;

  int checks = 0;
  int passes = 0;

  logic [EXP_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  branch_hist_ctrl_if #(.TAG_W(TAG_W)) bus();

  branch_hist_ctrl #(.W(W), .D(D), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .bus       (bus),
    .spec_hist (spec_hist),
    .arch_hist (arch_hist),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // ---------------- scoreboard / monitor ----------------
  task automatic check_field(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  logic [W-1:0]     e_spec, e_arch;
  logic [TAG_W:0]   e_cnt;
  logic             e_full, e_empty, e_ready;
  logic [TAG_W-1:0] e_tag;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      {e_spec, e_arch, e_cnt, e_full, e_empty, e_ready, e_tag} = exp_q.pop_front();
      check_field("spec_hist",     64'(spec_hist),         64'(e_spec));
      check_field("arch_hist",     64'(arch_hist),         64'(e_arch));
      check_field("count",         64'(count),             64'(e_cnt));
      check_field("full",          64'(full),              64'(e_full));
      check_field("empty",         64'(empty),             64'(e_empty));
      check_field("predict_ready", 64'(bus.predict_ready), 64'(e_ready));
      check_field("predict_tag",   64'(bus.predict_tag),   64'(e_tag));
    end
  end

  task automatic expect_state(input logic [W-1:0] sp, input logic [W-1:0] ar,
                              input int cnt, input int tag);
    logic [TAG_W:0]   c;
    logic [TAG_W-1:0] t;
    c = (TAG_W+1)'(cnt);
    t = TAG_W'(tag);
    exp_q.push_back({sp, ar, c, (cnt == D), (cnt == 0), (cnt != D), t});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic pv, input logic pt, input logic rv,
                       input logic [TAG_W-1:0] rtag, input logic rmis, input logic rtk,
                       input logic tv, input logic tt, input logic cl);
    bus.predict_valid      = pv;
    bus.predict_taken      = pt;
    bus.resolve_valid      = rv;
    bus.resolve_tag        = rtag;
    bus.resolve_mispredict = rmis;
    bus.resolve_taken      = rtk;
    bus.retire_valid       = tv;
    bus.retire_taken       = tt;
    clear                  = cl;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic predict(input logic t);
    drive(1, t, 0, '0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic retire(input logic t);
    drive(0, 0, 0, '0, 0, 0, 1, t, 0);
    tick();
  endtask

  task automatic mispredict(input logic [TAG_W-1:0] tag, input logic t);
    drive(0, 0, 1, tag, 1, t, 0, 0, 0);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    tick();
    expect_state('0, '0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    idle();
    #2;
    expect_state('0, '0, 0, 0);          // during reset
    #10;
    reset = 1'b1;
    tick();
    expect_state('0, '0, 0, 0);          // out of reset

    // T, NT, T then retire 1,0,1
    predict(1); expect_state(32'h1, 32'h0, 1, 1);
    predict(0); expect_state(32'h2, 32'h0, 2, 2);
    predict(1); expect_state(32'h5, 32'h0, 3, 3);
    retire(1);  expect_state(32'h5, 32'h1, 2, 3);
    retire(0);  expect_state(32'h5, 32'h2, 1, 3);
    retire(1);  expect_state(32'h5, 32'h5, 0, 3);

    // fill to full, drop a 9th predict, wrap the tag
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      predict(1);
      expect_state(32'((64'd1 << k) - 64'd1), 32'h0, k, k % 8);
    end
    predict(0); expect_state(32'hFF,  32'h0, 8, 0);
    retire(1);  expect_state(32'hFF,  32'h1, 7, 0);
    predict(0); expect_state(32'h1FE, 32'h1, 8, 1);
    // live range wraps (head idx 1, tail idx 1 next lap); repair at tag 7
    mispredict(3'd7, 0); expect_state(32'hFE, 32'h1, 7, 0);

    // mispredict in the middle of three taken predicts
    do_reset();
    predict(1); expect_state(32'h1, 32'h0, 1, 1);
    predict(1); expect_state(32'h3, 32'h0, 2, 2);
    predict(1); expect_state(32'h7, 32'h0, 3, 3);
    mispredict(3'd1, 0); expect_state(32'h2, 32'h0, 2, 2);

    // predict coinciding with mispredict on tag 0 is dropped
    drive(1, 1, 1, 3'd0, 1, 1, 0, 0, 0); tick();
    expect_state(32'h1, 32'h0, 1, 1);
    // predict coinciding with clear is dropped
    drive(1, 1, 0, 3'd0, 0, 0, 0, 0, 1); tick();
    expect_state(32'h0, 32'h0, 0, 1);

    // clear with retire: spec follows post-retire arch
    predict(1); expect_state(32'h1, 32'h0, 1, 2);
    drive(0, 0, 0, 3'd0, 0, 0, 1, 1, 1); tick();
    expect_state(32'h1, 32'h1, 0, 2);
    // retire while empty is ignored
    retire(1);  expect_state(32'h1, 32'h1, 0, 2);

    // mispredict on the head tag with concurrent retire empties the queue
    predict(0); expect_state(32'h2, 32'h1, 1, 3);
    drive(0, 0, 1, 3'd2, 1, 1, 1, 1, 0); tick();
    expect_state(32'h3, 32'h3, 0, 3);

    // correct resolve changes nothing
    predict(1); expect_state(32'h7, 32'h3, 1, 4);
    drive(0, 0, 1, 3'd3, 0, 0, 0, 0, 0); tick();
    expect_state(32'h7, 32'h3, 1, 4);

    // build to count 5, then reset asynchronously between edges
    predict(1); expect_state(32'hF,  32'h3, 2, 5);
    predict(1); expect_state(32'h1F, 32'h3, 3, 6);
    predict(1); expect_state(32'h3F, 32'h3, 4, 7);
    predict(1);                          // count 5; checked via reset below
    #1;
    reset = 1'b0;
    #1;
    expect_state('0, '0, 0, 0);          // sampled before the next posedge
    @(negedge clk);
    #1;
    reset = 1'b1;
    tick();
    expect_state('0, '0, 0, 0);

    // let the monitor drain, bounded
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/branch_hist_ctrl.md
# branch_hist_ctrl

Controller for the global branch-history shift register in the fetch/predict front end. Keeps a speculative history (shifted at prediction time) and an architectural history (shifted at retire). Checkpoints the speculative history per in-flight branch in a circular queue, so a mispredict restores and repairs history in one cycle and squashes all younger checkpoints. A pipeline clear resynchronises speculative history to architectural history.

## Interface
Parameters:
- `W`, 32, history length in bits.
- `D`, 8, checkpoint queue depth; power of two, at least 2.
- `TAG_W`, `$clog2(D)`, checkpoint tag width (derived).

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous pipeline flush; spec history := arch history, queue emptied.
- `predict_valid`  in  1  a conditional branch is predicted this cycle.
- `predict_taken`  in  1  predicted direction.
- `predict_ready`  out  1  `!full`; a predict while not ready is ignored.
- `predict_tag`  out  TAG_W  checkpoint tag allocated by the current predict (= tail index).
- `resolve_valid`  in  1  branch resolution.
- `resolve_tag`  in  TAG_W  tag of the resolving branch; always a live entry.
- `resolve_mispredict`  in  1  resolved direction differs from prediction.
- `resolve_taken`  in  1  actual direction.
- `retire_valid`  in  1  oldest live branch retires.
- `retire_taken`  in  1  actual direction of the retiring branch.
- `spec_hist`  out  W  speculative history; bit 0 is newest.
- `arch_hist`  out  W  architectural history.
- `count`  out  TAG_W+1  live checkpoints.
- `full`  out  1  `count == D`.
- `empty`  out  1  `count == 0`.

## Operation
- Shift convention: `h_next = {h[W-2:0], bit}`.
- Queue: head and tail pointers of TAG_W+1 bits, where the MSB is the wrap bit. `count = tail - head` mod 2^(TAG_W+1). `full` = indices equal and wrap bits differ.
- Predict, when accepted: `ckpt[tail] := spec_hist` (pre-shift value); spec_hist shifts in `predict_taken`; tail increments.
- Resolve with mispredict:
  - spec_hist := `{ckpt[resolve_tag][W-2:0], resolve_taken}`.
  - tail := position after resolve_tag, keeping the head-relative wrap bit.
  - All younger entries are squashed.
- Resolve without mispredict: no state change.
- Retire: arch_hist shifts in `retire_taken`; head increments. Retire while empty is a protocol error; the block ignores it and keeps head unchanged.
- Priority within one cycle: clear > mispredict > predict. A predict coinciding with clear or mispredict is dropped; it is not allocated.
- Retire is independent and applies in the same cycle as any of the above.
- clear with retire: arch_hist takes the retire shift, and spec_hist := the post-retire arch_hist. Head := tail.
- Mispredict on the head tag with a concurrent retire: the head entry is freed, tail = head+1, so the queue ends empty.
- Reset values: spec_hist = 0, arch_hist = 0, head = tail = 0, count = 0, empty = 1, full = 0, predict_ready = 1, predict_tag = 0. Checkpoint contents are don't-care.

## Timing
- All state changes are visible on outputs the cycle after the triggering input.
- `predict_ready`, `predict_tag`, `full`, `empty`, `count` are combinational from registered pointers only. There is no path from any input to any output.
- Throughput: one predict, one resolve and one retire per cycle.
- Mispredict repair: spec_hist is corrected in 1 cycle, and a predict is accepted again on the following cycle.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of `clk`.

## Structure
- Package `bh_pkg`: `hist_t` (logic [W-1:0] via parameterised typedef or localparam default), `ptr_t`, and helper function `hist_shift(h, b)`.
- Sub-module `bh_ckpt_queue`:
  - D×W register array.
  - head/tail pointers, count/full/empty.
  - One write port at tail and one asynchronous read port at resolve_tag.
  - Inputs: push, pop, truncate-to-tag, flush.
- Top level holds spec_hist/arch_hist registers and the priority logic.

## Test plan
- Reset, then predict taken, not-taken, taken -> spec_hist = 0b101, count = 3, tags 0,1,2. Retire the 3 branches as 1,0,1 -> arch_hist = 0b101, empty = 1.
- Predict 8 branches with D=8 -> full = 1, predict_ready = 0. A 9th predict leaves spec_hist and count unchanged. One retire -> ready the next cycle, and the next tag is 0 (wrap).
- Predict T,T,T (tags 0..2); mispredict tag 1 with resolve_taken=0 -> spec_hist = 0b10, count = 2, next predict_tag = 2.
- Same cycle: predict_valid=1 and mispredict on tag 0 -> the predict is dropped and count = 1. Same cycle: clear and predict -> count = 0, spec_hist = arch_hist.
- Same cycle: clear and retire_taken=1 with arch_hist = 0b0 -> arch_hist = spec_hist = 0b1, empty = 1.
- Assert reset asynchronously mid-stream with count = 5 -> all outputs at reset values before the next clk edge.
